// File: rtl/tube_p_bridge.sv
// tube_p_bridge: parasite-side bridge from the core's one-cycle request port
// to the tube's timed p_cs_b / p_rd_b / p_wr_b strobes, plus synchronisers
// for the tube's open-drain NMI and IRQ lines.
//
// Optional feature: define TUBE_P_BRIDGE_POSTED_WRITE_EN to acknowledge
// writes in the first SETUP cycle. busy still covers the whole access.
// Reads are not affected.
module tube_p_bridge #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       p_clk,
    input  logic       p_rst_b,
    input  logic       req,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       busy,
    output logic [2:0] p_addr,
    output logic       p_cs_b,
    output logic       p_rd_b,
    output logic       p_wr_b,
    output logic [7:0] p_data_o,
    output logic       p_data_oe,
    input  logic [7:0] p_data_i,
    input  logic       p_nmi_b_in,
    input  logic       p_irq_b_in,
    output logic       nmi_req,
    output logic       irq_level
);

`ifdef TUBE_P_BRIDGE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    // The counter holds "cycles left minus one", so each state is loaded
    // with its length less one and is left when the counter reads zero.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Access FSM registers and their next-state values
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_we;
    logic [2:0] r_addr;
    logic       r_cs_b;
    logic       r_rd_b;
    logic       r_wr_b;
    logic [7:0] r_data_o;
    logic       r_data_oe;
    logic [7:0] r_rdata;
    logic       r_ack;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_we_nxt;
    logic [2:0] w_addr_nxt;
    logic       w_cs_b_nxt;
    logic       w_rd_b_nxt;
    logic       w_wr_b_nxt;
    logic [7:0] w_data_o_nxt;
    logic       w_data_oe_nxt;
    logic [7:0] w_rdata_nxt;
    logic       w_ack_nxt;
    logic       w_busy_nxt;

    // Next-state and next-output decode for the access sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_we_nxt      = r_we;
        w_addr_nxt    = r_addr;
        w_cs_b_nxt    = r_cs_b;
        w_rd_b_nxt    = r_rd_b;
        w_wr_b_nxt    = r_wr_b;
        w_data_o_nxt  = r_data_o;
        w_data_oe_nxt = r_data_oe;
        w_rdata_nxt   = r_rdata;
        w_ack_nxt     = 1'b0;
        w_busy_nxt    = r_busy;

        case (r_state)
            ST_IDLE: begin
                // busy is low throughout IDLE, so IDLE alone gates acceptance.
                if (req) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = SETUP_LD;
                    w_we_nxt    = we;
                    w_addr_nxt  = addr;
                    w_cs_b_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    if (we) begin
                        w_data_oe_nxt = 1'b1;
                        w_data_o_nxt  = wdata;
                    end
                    w_ack_nxt = POSTED && we;
                end
            end

            ST_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = STROBE_LD;
                    if (r_we) w_wr_b_nxt = 1'b0;
                    else      w_rd_b_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            ST_STROBE: begin
                if (r_cnt == 4'd0) begin
                    // The strobe rises with cs/addr/data still stable; a read
                    // samples the pad on that same edge.
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LD;
                    w_rd_b_nxt  = 1'b1;
                    w_wr_b_nxt  = 1'b1;
                    if (!r_we) w_rdata_nxt = p_data_i;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = 4'd0;
                    w_cs_b_nxt    = 1'b1;
                    w_data_oe_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                    // A posted write has already been acknowledged.
                    w_ack_nxt     = !(POSTED && r_we);
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; a tube reset drops every strobe at once.
    always_ff @(posedge p_clk or negedge p_rst_b) begin
        if (!p_rst_b) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= 3'd0;
            r_cs_b    <= 1'b1;
            r_rd_b    <= 1'b1;
            r_wr_b    <= 1'b1;
            r_data_o  <= 8'd0;
            r_data_oe <= 1'b0;
            r_rdata   <= 8'd0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // values sampled before the edge, independent of statement order.
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_cs_b    <= w_cs_b_nxt;
            r_rd_b    <= w_rd_b_nxt;
            r_wr_b    <= w_wr_b_nxt;
            r_data_o  <= w_data_o_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_rdata   <= w_rdata_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign p_addr    = r_addr;
    assign p_cs_b    = r_cs_b;
    assign p_rd_b    = r_rd_b;
    assign p_wr_b    = r_wr_b;
    assign p_data_o  = r_data_o;
    assign p_data_oe = r_data_oe;
    assign rdata     = r_rdata;
    assign ack       = r_ack;
    assign busy      = r_busy;

    // ------------------------------------------------------------------
    // Interrupt synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_nmi_sync;
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic [SYNC_STAGES-1:0] r_sync_fill;
    logic                   r_nmi_prev;
    logic                   r_nmi_req;
    logic                   r_irq_level;

    logic w_nmi_s;
    logic w_irq_s;
    logic w_sync_valid;

    assign w_nmi_s      = r_nmi_sync[SYNC_STAGES-1];
    assign w_irq_s      = r_irq_sync[SYNC_STAGES-1];
    // The chain output is a real sample (not reset residue) once a 1 has
    // walked through the fill register alongside it.
    assign w_sync_valid = r_sync_fill[SYNC_STAGES-1];

    // Shift the pads through the synchronisers and detect the NMI fall.
    always_ff @(posedge p_clk or negedge p_rst_b) begin
        if (!p_rst_b) begin
            // NOTE: synchroniser flops reset to the idle (pulled-up) level so
            // reset release never looks like an interrupt edge.
            r_nmi_sync  <= '1;
            r_irq_sync  <= '1;
            r_sync_fill <= '0;
            // Cleared so an NMI already low at reset release is treated as
            // an old level rather than a new edge.
            r_nmi_prev  <= 1'b0;
            r_nmi_req   <= 1'b0;
            r_irq_level <= 1'b0;
        end else begin
            r_nmi_sync  <= {r_nmi_sync[SYNC_STAGES-2:0], p_nmi_b_in};
            r_irq_sync  <= {r_irq_sync[SYNC_STAGES-2:0], p_irq_b_in};
            r_sync_fill <= {r_sync_fill[SYNC_STAGES-2:0], 1'b1};
            r_nmi_prev  <= w_sync_valid ? w_nmi_s : 1'b0;
            r_nmi_req   <= w_sync_valid && r_nmi_prev && !w_nmi_s;
            r_irq_level <= !w_irq_s;
        end
    end

    assign nmi_req   = r_nmi_req;
    assign irq_level = r_irq_level;

endmodule

// File: tb/tb_tube_p_bridge.sv
// Directed testbench for tube_p_bridge. Instance a uses default timing,
// instance b uses SETUP=2 / STROBE=3 / HOLD=2. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_tube_p_bridge;

`ifdef TUBE_P_BRIDGE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic       req_b;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] p_data_i;
    logic       nmi_b;
    logic       irq_b;

    logic [7:0] rdata_a, rdata_b, data_o_a, data_o_b;
    logic [2:0] paddr_a, paddr_b;
    logic       ack_a, ack_b, busy_a, busy_b;
    logic       cs_a, cs_b, rd_a, rd_b, wr_a, wr_b, oe_a, oe_b;
    logic       nmi_a, nmi_bb, irql_a, irql_b;

    int total = 0;
    int bad   = 0;

    // Selected-instance view used by the generic access checker.
    bit         sel;
    logic [7:0] m_rdata, m_data_o;
    logic [2:0] m_addr;
    logic       m_ack, m_busy, m_cs, m_rd, m_wr, m_oe;

    always_comb begin
        m_rdata  = sel ? rdata_b  : rdata_a;
        m_data_o = sel ? data_o_b : data_o_a;
        m_addr   = sel ? paddr_b  : paddr_a;
        m_ack    = sel ? ack_b    : ack_a;
        m_busy   = sel ? busy_b   : busy_a;
        m_cs     = sel ? cs_b     : cs_a;
        m_rd     = sel ? rd_b     : rd_a;
        m_wr     = sel ? wr_b     : wr_a;
        m_oe     = sel ? oe_b     : oe_a;
    end

    tube_p_bridge u_dut_a (
        .p_clk(clk), .p_rst_b(rst_n), .req(req_a), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_a), .ack(ack_a), .busy(busy_a),
        .p_addr(paddr_a), .p_cs_b(cs_a), .p_rd_b(rd_a), .p_wr_b(wr_a),
        .p_data_o(data_o_a), .p_data_oe(oe_a), .p_data_i(p_data_i),
        .p_nmi_b_in(nmi_b), .p_irq_b_in(irq_b), .nmi_req(nmi_a),
        .irq_level(irql_a)
    );

    tube_p_bridge #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .SYNC_STAGES(2)) u_dut_b (
        .p_clk(clk), .p_rst_b(rst_n), .req(req_b), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_b), .ack(ack_b), .busy(busy_b),
        .p_addr(paddr_b), .p_cs_b(cs_b), .p_rd_b(rd_b), .p_wr_b(wr_b),
        .p_data_o(data_o_b), .p_data_oe(oe_b), .p_data_i(p_data_i),
        .p_nmi_b_in(nmi_b), .p_irq_b_in(irq_b), .nmi_req(nmi_bb),
        .irq_level(irql_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on the selected instance, checked cycle by cycle. k counts
    // falling edges after the accepting rising edge (k=0 is the first SETUP
    // cycle). preset: caller already raised req. poke: raise a stray req while
    // busy. chain: return in the ack cycle so the caller can request again.
    task automatic run_access(input bit s_in, input bit w, input logic [2:0] a,
                              input logic [7:0] wd, input logic [7:0] din,
                              input int s, input int t, input int h,
                              input bit preset, input bit poke, input bit chain,
                              input string tag);
        int n;
        logic e_cs, e_rd, e_wr, e_busy, e_ack;
        n = s + t + h;
        sel = s_in;
        if (!preset) begin
            @(negedge clk);
            we = w; addr = a; wdata = wd; p_data_i = 8'h00;
            if (s_in) req_b = 1'b1; else req_a = 1'b1;
        end
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        for (int k = 0; k <= n + 1; k++) begin
            if (k == s) p_data_i = din;
            e_cs   = (k >= n);
            e_busy = (k < n);
            e_rd   = !(!w && k >= s && k < s + t);
            e_wr   = !(w && k >= s && k < s + t);
            e_ack  = (POSTED && w) ? (k == 0) : (k == n);
            total++;
            if (m_cs !== e_cs) begin
                bad++; $display("FAIL %s p_cs_b k=%0d got=%b exp=%b", tag, k, m_cs, e_cs);
            end
            total++;
            if (m_rd !== e_rd) begin
                bad++; $display("FAIL %s p_rd_b k=%0d got=%b exp=%b", tag, k, m_rd, e_rd);
            end
            total++;
            if (m_wr !== e_wr) begin
                bad++; $display("FAIL %s p_wr_b k=%0d got=%b exp=%b", tag, k, m_wr, e_wr);
            end
            total++;
            if (m_busy !== e_busy) begin
                bad++; $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, m_busy, e_busy);
            end
            total++;
            if (m_ack !== e_ack) begin
                bad++; $display("FAIL %s ack k=%0d got=%b exp=%b", tag, k, m_ack, e_ack);
            end
            total++;
            if (m_oe !== (w && k < n)) begin
                bad++; $display("FAIL %s p_data_oe k=%0d got=%b exp=%b", tag, k, m_oe, (w && k < n));
            end
            if (k < n) begin
                total++;
                if (m_addr !== a) begin
                    bad++; $display("FAIL %s p_addr k=%0d got=%h exp=%h", tag, k, m_addr, a);
                end
                if (w) begin
                    total++;
                    if (m_data_o !== wd) begin
                        bad++; $display("FAIL %s p_data_o k=%0d got=%h exp=%h", tag, k, m_data_o, wd);
                    end
                end
            end
            if (!w && k >= s + t) begin
                total++;
                if (m_rdata !== din) begin
                    bad++; $display("FAIL %s rdata k=%0d got=%h exp=%h", tag, k, m_rdata, din);
                end
            end
            if (poke && k == 1) begin
                we = ~w; addr = ~a; wdata = ~wd;
                if (s_in) req_b = 1'b1; else req_a = 1'b1;
            end
            if (poke && k == 2) begin
                req_a = 1'b0; req_b = 1'b0;
            end
            if (chain && k == n) return;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({cs_a, rd_a, wr_a} !== 3'b111) begin
            bad++; $display("FAIL reset strobes got=%b exp=111", {cs_a, rd_a, wr_a});
        end
        total++;
        if ({paddr_a, data_o_a, oe_a} !== 12'h000) begin
            bad++; $display("FAIL reset pad got=%h exp=000", {paddr_a, data_o_a, oe_a});
        end
        total++;
        if ({rdata_a, ack_a, busy_a} !== 10'h000) begin
            bad++; $display("FAIL reset core got=%h exp=000", {rdata_a, ack_a, busy_a});
        end
        total++;
        if ({nmi_a, irql_a, cs_b, busy_b} !== 4'b0010) begin
            bad++; $display("FAIL reset irq/b got=%b exp=0010", {nmi_a, irql_a, cs_b, busy_b});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read();
        run_access(1'b0, 1'b0, 3'b101, 8'h00, 8'h96, 1, 2, 1, 1'b0, 1'b0, 1'b0, "read_a");
        run_access(1'b1, 1'b0, 3'b110, 8'h00, 8'h3C, 2, 3, 2, 1'b0, 1'b0, 1'b0, "read_b");
    endtask

    task automatic test_write();
        run_access(1'b1, 1'b1, 3'b001, 8'h5A, 8'h00, 2, 3, 2, 1'b0, 1'b0, 1'b0, "write_b");
        run_access(1'b0, 1'b1, 3'b010, 8'hE7, 8'h00, 1, 2, 1, 1'b0, 1'b0, 1'b0, "write_a");
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 1'b0, 3'd2, 8'h00, 8'h11, 1, 2, 1, 1'b0, 1'b0, 1'b1, "b2b_first");
        we = 1'b1; addr = 3'd6; wdata = 8'hC3; p_data_i = 8'h00; req_a = 1'b1;
        run_access(1'b0, 1'b1, 3'd6, 8'hC3, 8'h00, 1, 2, 1, 1'b1, 1'b1, 1'b0, "b2b_second");
        // The request raised while busy must never turn into an access.
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({cs_a, ack_a, busy_a} !== 3'b100) begin
                bad++; $display("FAIL dropped_req k=%0d got=%b exp=100", k, {cs_a, ack_a, busy_a});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        we = 1'b1; addr = 3'd3; wdata = 8'hA5; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        total++;
        if ({cs_a, wr_a} !== 2'b00) begin
            bad++; $display("FAIL mid_rst in_strobe got=%b exp=00", {cs_a, wr_a});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cs_a, rd_a, wr_a, busy_a, ack_a, oe_a} !== 6'b111000) begin
            bad++; $display("FAIL mid_rst immediate got=%b exp=111000",
                            {cs_a, rd_a, wr_a, busy_a, ack_a, oe_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({cs_a, ack_a, busy_a} !== 3'b100) begin
                bad++; $display("FAIL mid_rst no_ack k=%0d got=%b exp=100", k, {cs_a, ack_a, busy_a});
            end
        end
        run_access(1'b0, 1'b0, 3'd4, 8'h00, 8'h69, 1, 2, 1, 1'b0, 1'b0, 1'b0, "mid_rst_read");
    endtask

    task automatic test_nmi_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2 nmi_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (nmi_a !== 1'b0) begin
                bad++; $display("FAIL nmi_low_at_reset k=%0d got=%b exp=0", k, nmi_a);
            end
        end
        nmi_b = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_nmi();
        #3 nmi_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (nmi_a !== (k == 3)) begin
                bad++; $display("FAIL nmi_pulse k=%0d got=%b exp=%b", k, nmi_a, (k == 3));
            end
            total++;
            if (nmi_bb !== (k == 3)) begin
                bad++; $display("FAIL nmi_pulse_b k=%0d got=%b exp=%b", k, nmi_bb, (k == 3));
            end
        end
        nmi_b = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_irq();
        irq_b = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            total++;
            if (irql_a !== (k >= 3 && k <= 12)) begin
                bad++; $display("FAIL irq_level k=%0d got=%b exp=%b", k, irql_a, (k >= 3 && k <= 12));
            end
            if (k == 10) irq_b = 1'b1;
        end
    endtask

    initial begin
        sel = 1'b0;
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        we = 1'b0; addr = 3'd0; wdata = 8'h00; p_data_i = 8'h00;
        nmi_b = 1'b1; irq_b = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_nmi_reset();
        test_nmi();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
